rom_uploader: RTL

ROM_UPLOADER -- requirements
Module: rom_uploader

---
 rtl/rom_uploader_if.sv | 25 ++
 rtl/rom_uploader.sv | 83 ++++++++
 2 files changed

// File: rtl/rom_uploader_if.sv
// rom_uploader_if: bundles the HPS ioctl upload port, the ROM image memory port and the session status.
//   master: HPS/memory side (drives the ioctl requests and mem_data)
//   slave : uploader side (drives ioctl_din/ioctl_wait, the memory strobe and the status)
interface rom_uploader_if;
    logic        ioctl_upload;
    logic        ioctl_rd;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;
    logic [24:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_data;
    logic [24:0] upload_count;
    logic [7:0]  upload_sum;
    logic        upload_done;
    logic        overrun;
    modport master (
        output ioctl_upload, ioctl_rd, ioctl_addr, mem_data,
        input  ioctl_din, ioctl_wait, mem_addr, mem_rd, upload_count, upload_sum, upload_done, overrun
    );
    modport slave (
        input  ioctl_upload, ioctl_rd, ioctl_addr, mem_data,
        output ioctl_din, ioctl_wait, mem_addr, mem_rd, upload_count, upload_sum, upload_done, overrun
    );
endinterface

// File: rtl/rom_uploader.sv
// rom_uploader: serves HPS byte reads of the ROM image, with per-session byte count and checksum.
//   CLK   : single clock
//   RESET : synchronous, active-high reset
//   bus   : rom_uploader_if.slave (ioctl request/response, memory read port, session status)
module rom_uploader #(
    parameter int IMAGE_SIZE   = 'h18000,
    parameter int READ_LATENCY = 1
) (
    input logic           CLK,
    input logic           RESET,
    rom_uploader_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAITDATA, CAPTURE} state_t;
    localparam logic [1:0] LAST = 2'(READ_LATENCY - 2);
    state_t      state, state_nxt;
    logic [1:0]  cnt;
    logic [24:0] addr_q, count_q, count_base;
    logic [7:0]  din_q, sum_q, sum_base, new_byte;
    logic        upload_q, done_q, overrun_q;
    logic        in_range, accept, take, oob, abort, deliver, rise, busy_rd;
    assign in_range   = 32'(bus.ioctl_addr) < IMAGE_SIZE;
    assign accept     = state == IDLE && bus.ioctl_upload && bus.ioctl_rd;
    assign take       = accept && in_range;
    assign oob        = accept && !in_range;
    assign abort      = state != IDLE && !bus.ioctl_upload;
    assign deliver    = state == CAPTURE && bus.ioctl_upload;
    assign busy_rd    = state != IDLE && bus.ioctl_upload && bus.ioctl_rd;
    assign rise       = bus.ioctl_upload && !upload_q;
    // a new session starts from zero even if a byte is delivered on the same edge
    assign count_base = rise ? '0 : count_q;
    assign sum_base   = rise ? '0 : sum_q;
    assign new_byte   = deliver ? bus.mem_data : 8'hFF;
    always_comb begin
        state_nxt = state;
        if (abort)
            state_nxt = IDLE;
        else if (take)
            state_nxt = ISSUE;
        else if (state == ISSUE)
            state_nxt = READ_LATENCY == 1 ? CAPTURE : WAITDATA;
        else if (state == WAITDATA && cnt == LAST)
            state_nxt = CAPTURE;
        else if (state == CAPTURE)
            state_nxt = IDLE;
    end
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            cnt       <= '0;
            addr_q    <= '0;
            din_q     <= '0;
            count_q   <= '0;
            sum_q     <= '0;
            upload_q  <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= state == WAITDATA ? cnt + 2'd1 : 2'd0;
            upload_q  <= bus.ioctl_upload;
            done_q    <= upload_q && !bus.ioctl_upload;
            overrun_q <= (rise ? 1'b0 : overrun_q) | busy_rd;
            if (take)
                addr_q <= bus.ioctl_addr;
            if (deliver || oob) begin
                din_q   <= new_byte;
                count_q <= count_base + 25'd1;
                sum_q   <= sum_base + new_byte;
            end else begin
                count_q <= count_base;
                sum_q   <= sum_base;
            end
        end
    end
    assign bus.mem_rd       = state == ISSUE;
    assign bus.mem_addr     = addr_q;
    assign bus.ioctl_wait   = state != IDLE;
    assign bus.ioctl_din    = din_q;
    assign bus.upload_count = count_q;
    assign bus.upload_sum   = sum_q;
    assign bus.upload_done  = done_q;
    assign bus.overrun      = overrun_q;
endmodule
